// File: rtl/spi_pkg.sv
// Shared definitions for the FIFO-buffered SPI master: register map, bit positions, FSM states.
package spi_pkg;
  localparam logic [2:0] REG_DIV    = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_CSEL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_RX_EMPTY = 4;
  localparam int STAT_RX_OVF   = 5;

  localparam int CTRL_CPHA = 0;
  localparam int CTRL_CPOL = 1;
  localparam int CTRL_LSB  = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} spi_state_e;

  // Outgoing end of the shifter and the shifter after one bit has left.
  function automatic logic out_bit(input logic [7:0] sr, input logic lsb);
    return lsb ? sr[0] : sr[7];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] sr, input logic lsb);
    return lsb ? {1'b0, sr[7:1]} : {sr[6:0], 1'b0};
  endfunction
endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO; push ignored when full, pop ignored when empty.
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX FIFOs, all four modes, MSB/LSB first, software chip selects.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int NUM_CS     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs,
  input  logic              i_rwb,
  input  logic [2:0]        i_addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic [NUM_CS-1:0] o_spi_cs_n,
  output logic              o_spi_clk,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);
  logic [DIV_WIDTH-1:0] div_q, div_sh, div_cnt;
  logic [2:0]           ctrl_q;
  logic [NUM_CS-1:0]    csel_q;
  logic                 rx_ovf_q;
  logic                 cpha_sh, lsb_sh;
  logic [3:0]           edge_cnt;
  logic [7:0]           tx_sr, rx_sr, rx_next, rx_din;
  spi_state_e           state_q, state_d;

  logic wr, rd, tx_pop, rx_push, tick, sample, shift, busy;
  logic [7:0] tx_dout, rx_dout;
  logic tx_full, tx_empty, rx_full, rx_empty;

  assign wr = i_cs & ~i_rwb;
  assign rd = i_cs & i_rwb;

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rst(i_rst),
    .push(wr && i_addr == REG_DATA), .pop(tx_pop),
    .din(i_data), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(i_clk), .rst(i_rst),
    .push(rx_push), .pop(rd && i_addr == REG_DATA),
    .din(rx_din), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign busy = (state_q != ST_IDLE) | ~tx_empty;

  // Edge parity: edge_cnt holds edges already made, so the upcoming edge is odd when edge_cnt is even.
  assign sample  = tick & (cpha_sh ? edge_cnt[0] : ~edge_cnt[0]);
  assign shift   = tick & (cpha_sh ? ~edge_cnt[0] : (edge_cnt[0] && edge_cnt != 4'd15));
  assign rx_next = lsb_sh ? {i_spi_miso, rx_sr[7:1]} : {rx_sr[6:0], i_spi_miso};
  assign rx_din  = sample ? rx_next : rx_sr;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    tick    = 1'b0;
    case (state_q)
      ST_IDLE: if (!tx_empty) begin
        tx_pop  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (div_cnt == div_sh) begin
        tick = 1'b1;
        if (edge_cnt == 4'd15) begin
          rx_push = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q    <= DIV_WIDTH'(1);
      ctrl_q   <= '0;
      csel_q   <= '0;
      rx_ovf_q <= 1'b0;
    end else begin
      if (wr) begin
        case (i_addr)
          REG_DIV:    div_q  <= DIV_WIDTH'(i_data);
          REG_CTRL:   ctrl_q <= i_data[2:0];
          REG_CSEL:   csel_q <= i_data[NUM_CS-1:0];
          REG_STATUS: if (i_data[STAT_RX_OVF]) rx_ovf_q <= 1'b0;
          default: ;
        endcase
      end
      if (rx_push && rx_full) rx_ovf_q <= 1'b1;
    end
  end

  // Divider, shifter and serial outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_sh     <= '0;
      div_cnt    <= '0;
      cpha_sh    <= 1'b0;
      lsb_sh     <= 1'b0;
      edge_cnt   <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      o_spi_clk  <= 1'b0;
      o_spi_mosi <= 1'b0;
      o_spi_cs_n <= '1;
    end else begin
      o_spi_cs_n <= ~csel_q;
      if (state_q == ST_IDLE) o_spi_clk <= ctrl_q[CTRL_CPOL];
      if (tx_pop) begin
        div_sh   <= div_q;
        cpha_sh  <= ctrl_q[CTRL_CPHA];
        lsb_sh   <= ctrl_q[CTRL_LSB];
        div_cnt  <= '0;
        edge_cnt <= '0;
        rx_sr    <= '0;
        // CPHA=0 presents the first bit at load, so the shifter starts one bit ahead.
        if (ctrl_q[CTRL_CPHA]) begin
          tx_sr <= tx_dout;
        end else begin
          tx_sr      <= shift_out(tx_dout, ctrl_q[CTRL_LSB]);
          o_spi_mosi <= out_bit(tx_dout, ctrl_q[CTRL_LSB]);
        end
      end else if (state_q == ST_SHIFT) begin
        if (tick) begin
          div_cnt   <= '0;
          edge_cnt  <= edge_cnt + 4'd1;
          o_spi_clk <= ~o_spi_clk;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (shift) begin
          o_spi_mosi <= out_bit(tx_sr, lsb_sh);
          tx_sr      <= shift_out(tx_sr, lsb_sh);
        end
        if (sample) rx_sr <= rx_next;
      end
    end
  end

  always_comb begin
    o_data = 8'h00;
    case (i_addr)
      REG_DIV:    o_data = 8'(div_q);
      REG_DATA:   o_data = rx_empty ? 8'h00 : rx_dout;
      REG_CTRL:   o_data = {5'b0, ctrl_q};
      REG_CSEL:   o_data = 8'(csel_q);
      REG_STATUS: begin
        o_data[STAT_BUSY]     = busy;
        o_data[STAT_TX_FULL]  = tx_full;
        o_data[STAT_TX_EMPTY] = tx_empty;
        o_data[STAT_RX_FULL]  = rx_full;
        o_data[STAT_RX_EMPTY] = rx_empty;
        o_data[STAT_RX_OVF]   = rx_ovf_q;
      end
      default: o_data = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_spi_master_fifo.sv
// Bench for spi_master_fifo: SPI slave model on the pins, register-level stimulus, queue-based expectations.
module tb_spi_master_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0, rwb = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'h00, rdata;
  logic [3:0] cs_n;
  logic       sclk, mosi, miso;

  always #5 clk = ~clk;

  spi_master_fifo #(.NUM_CS(4), .FIFO_DEPTH(4), .DIV_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_rwb(rwb), .i_addr(addr), .i_data(wdata),
    .o_data(rdata), .o_spi_cs_n(cs_n), .o_spi_clk(sclk), .o_spi_mosi(mosi), .i_spi_miso(miso)
  );

  int n_tests = 0, n_fail = 0;

  // Slave model state: the monitor is the only writer of these.
  int         edges = 0, nbytes = 0, nedges = 0;
  logic       prev = 1'b0;
  logic [7:0] sh = 8'h00, cur_slave = 8'h00;
  logic [7:0] mon_bytes [64];
  time        edge_t [1024];
  // Written only by the stimulus process.
  logic [7:0] slave_data [64];
  logic       cur_cpha = 1'b0, cur_lsb = 1'b0, loopb = 1'b0, mon_clear = 1'b0;
  time        last_wr_t = 0;

  // Slave samples MOSI on the mode's capture edge and rebuilds each 16-edge byte.
  always @(negedge clk) begin
    if (mon_clear) begin
      edges = 0; nbytes = 0; nedges = 0; prev = sclk; sh = 8'h00; cur_slave = slave_data[0];
    end else if (sclk !== prev) begin
      prev = sclk;
      edges = edges + 1;
      if (nedges < 1024) edge_t[nedges] = $time;
      nedges = nedges + 1;
      if ((!cur_cpha && (edges % 2 == 1)) || (cur_cpha && (edges % 2 == 0)))
        sh = cur_lsb ? {mosi, sh[7:1]} : {sh[6:0], mosi};
      if (edges == 16) begin
        if (nbytes < 64) mon_bytes[nbytes] = sh;
        nbytes = nbytes + 1;
        edges = 0;
        cur_slave = slave_data[nbytes % 64];
      end
    end
  end

  // Slave drive: bit k is presented before the first edge (CPHA=0) or after edge 2k+1 (CPHA=1).
  always @* begin
    int k;
    logic [2:0] idx;
    k = cur_cpha ? (edges - 1) / 2 : edges / 2;
    if (k < 0) k = 0;
    if (k > 7) k = 7;
    idx = 3'(k);
    miso = loopb ? mosi : (cur_lsb ? cur_slave[idx] : cur_slave[3'd7 - idx]);
  end

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b0; addr = a; wdata = d; last_wr_t = $time;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rwb = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    cs = 1'b0; rwb = 1'b0;
  endtask

  task automatic clear_mon();
    @(posedge clk); #2 mon_clear = 1'b1;
    @(posedge clk); #2 mon_clear = 1'b0;
  endtask

  task automatic set_mode(input logic cpha, input logic cpol, input logic lsb, input logic [7:0] div);
    reg_wr(3'd0, div);
    reg_wr(3'd2, {5'b0, lsb, cpol, cpha});
    cur_cpha = cpha; cur_lsb = lsb;
    repeat (3) @(negedge clk);
    clear_mon();
  endtask

  task automatic wait_bytes(input int n);
    int c = 0;
    while (nbytes < n && c < 5000) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    if (nbytes < n) begin
      n_tests++; n_fail++;
      $display("FAIL wait_bytes: got %0d bytes, required %0d", nbytes, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    n_tests++; if (cs_n !== 4'hF) begin n_fail++; $display("FAIL reset_cs_n: got %h, required f", cs_n); end
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b, required 0", sclk); end
    n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b, required 0", mosi); end
    reg_rd(3'd4, d);
    n_tests++; if (d !== 8'h14) begin n_fail++; $display("FAIL reset_status: got %h, required 14", d); end
    reg_rd(3'd0, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL reset_div: got %h, required 01", d); end
    reg_rd(3'd2, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h, required 00", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    reg_wr(3'd2, 8'hFF); reg_rd(3'd2, d);
    n_tests++; if (d !== 8'h07) begin n_fail++; $display("FAIL ctrl_mask: got %h, required 07", d); end
    reg_wr(3'd3, 8'hFF); reg_rd(3'd3, d);
    n_tests++; if (d !== 8'h0F) begin n_fail++; $display("FAIL csel_mask: got %h, required 0f", d); end
    n_tests++; if (cs_n !== 4'h0) begin n_fail++; $display("FAIL csel_pins: got %h, required 0", cs_n); end
    for (int a = 5; a < 8; a++) begin
      reg_wr(3'(a), 8'hFF); reg_rd(3'(a), d);
      n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL unmapped_%0d: got %h, required 00", a, d); end
    end
    reg_wr(3'd2, 8'h00); reg_wr(3'd3, 8'h00);
  endtask

  task automatic test_mode0();
    logic [7:0] d;
    int bad = 0;
    loopb = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0, 8'd1);
    reg_wr(3'd3, 8'h01);
    @(negedge clk);
    n_tests++; if (cs_n !== 4'b1110) begin n_fail++; $display("FAIL m0_cs_n: got %b, required 1110", cs_n); end
    reg_wr(3'd1, 8'hA5);
    wait_bytes(1);
    n_tests++; if (mon_bytes[0] !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi: got %h, required a5", mon_bytes[0]); end
    n_tests++; if (nedges != 16) begin n_fail++; $display("FAIL m0_edges: got %0d, required 16", nedges); end
    n_tests++; if (edge_t[0] - last_wr_t != 40) begin n_fail++; $display("FAIL m0_first_edge: got %0d, required 40", int'(edge_t[0] - last_wr_t)); end
    for (int i = 1; i < 16; i++) if (edge_t[i] - edge_t[i-1] != 20) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL m0_spacing: got %0d bad gaps, required 0", bad); end
    reg_rd(3'd1, d);
    n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL m0_rx: got %h, required a5", d); end
    reg_rd(3'd4, d);
    n_tests++; if (d !== 8'h14) begin n_fail++; $display("FAIL m0_status: got %h, required 14", d); end
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] d;
    int bad = 0;
    loopb = 1'b0;
    slave_data[0] = 8'hFF;
    set_mode(1'b1, 1'b1, 1'b1, 8'd0);
    n_tests++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_idle_sclk: got %b, required 1", sclk); end
    reg_wr(3'd1, 8'h01);
    wait_bytes(1);
    n_tests++; if (mon_bytes[0] !== 8'h01) begin n_fail++; $display("FAIL m3_mosi: got %h, required 01", mon_bytes[0]); end
    n_tests++; if (edge_t[0] - last_wr_t != 30) begin n_fail++; $display("FAIL m3_first_edge: got %0d, required 30", int'(edge_t[0] - last_wr_t)); end
    for (int i = 1; i < 16; i++) if (edge_t[i] - edge_t[i-1] != 10) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL m3_spacing: got %0d bad gaps, required 0", bad); end
    n_tests++; if (sclk !== 1'b1) begin n_fail++; $display("FAIL m3_end_sclk: got %b, required 1", sclk); end
    reg_rd(3'd1, d);
    n_tests++; if (d !== 8'hFF) begin n_fail++; $display("FAIL m3_rx: got %h, required ff", d); end
  endtask

  task automatic test_tx_fill();
    logic [7:0] d, exp_st;
    logic [7:0] exp_tx[$];
    int tx_cnt = 0, bad = 0;
    loopb = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0, 8'd1);
    reg_wr(3'd1, 8'h0F);
    exp_tx.push_back(8'h0F);
    repeat (3) @(negedge clk);
    for (int v = 8'h10; v <= 8'h14; v++) begin
      reg_wr(3'd1, 8'(v));
      if (tx_cnt < 4) begin exp_tx.push_back(8'(v)); tx_cnt++; end
    end
    reg_rd(3'd4, d);
    exp_st = {3'b0, 1'b1, 1'b0, 1'b0, (tx_cnt == 4), 1'b1};
    n_tests++; if (d !== exp_st) begin n_fail++; $display("FAIL fill_status: got %h, required %h", d, exp_st); end
    wait_bytes(exp_tx.size());
    repeat (100) @(negedge clk);
    n_tests++; if (nbytes != exp_tx.size()) begin n_fail++; $display("FAIL fill_count: got %0d, required %0d", nbytes, exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      n_tests++; if (mon_bytes[i] !== exp_tx[i]) begin n_fail++; $display("FAIL fill_byte%0d: got %h, required %h", i, mon_bytes[i], exp_tx[i]); end
    end
    for (int i = 1; i < exp_tx.size(); i++) if (edge_t[16*i] - edge_t[16*i-1] != 30) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL fill_gap: got %0d bad gaps, required 0", bad); end
    reg_rd(3'd4, d);
    n_tests++; if (d !== 8'h2C) begin n_fail++; $display("FAIL fill_rx_status: got %h, required 2c", d); end
    for (int i = 0; i < 4; i++) begin
      reg_rd(3'd1, d);
      n_tests++; if (d !== exp_tx[i]) begin n_fail++; $display("FAIL fill_rx%0d: got %h, required %h", i, d, exp_tx[i]); end
    end
    reg_rd(3'd1, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL fill_rx_empty: got %h, required 00", d); end
    reg_wr(3'd4, 8'h20);
  endtask

  task automatic test_random();
    logic [7:0] d, txb, sb, dv;
    logic cpha, cpol, lsb;
    int bad;
    loopb = 1'b0;
    for (int it = 0; it < 8; it++) begin
      cpha = 1'($urandom); cpol = 1'($urandom); lsb = 1'($urandom);
      dv = 8'($urandom_range(0, 3)); txb = 8'($urandom); sb = 8'($urandom);
      slave_data[0] = sb;
      set_mode(cpha, cpol, lsb, dv);
      reg_wr(3'd1, txb);
      wait_bytes(1);
      n_tests++; if (mon_bytes[0] !== txb) begin n_fail++; $display("FAIL rnd%0d_mosi: got %h, required %h", it, mon_bytes[0], txb); end
      n_tests++; if (edge_t[0] - last_wr_t != 10 * (dv + 2) + 10) begin n_fail++; $display("FAIL rnd%0d_first_edge: got %0d, required %0d", it, int'(edge_t[0] - last_wr_t), 10 * (dv + 2) + 10); end
      bad = 0;
      for (int i = 1; i < 16; i++) if (edge_t[i] - edge_t[i-1] != 10 * (dv + 1)) bad++;
      n_tests++; if (bad != 0 || nedges != 16) begin n_fail++; $display("FAIL rnd%0d_spacing: got %0d bad gaps %0d edges, required 0 and 16", it, bad, nedges); end
      reg_rd(3'd1, d);
      n_tests++; if (d !== sb) begin n_fail++; $display("FAIL rnd%0d_rx: got %h, required %h", it, d, sb); end
      reg_rd(3'd4, d);
      n_tests++; if (d !== 8'h14) begin n_fail++; $display("FAIL rnd%0d_status: got %h, required 14", it, d); end
    end
  endtask

  task automatic test_rx_ovf();
    logic [7:0] d;
    logic [7:0] rxq[$];
    logic ovf = 1'b0;
    loopb = 1'b0;
    for (int i = 0; i < 5; i++) slave_data[i] = 8'($urandom);
    set_mode(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 2)));
    for (int i = 0; i < 5; i++) begin
      reg_wr(3'd1, 8'($urandom));
      wait_bytes(i + 1);
      if (rxq.size() < 4) rxq.push_back(slave_data[i]); else ovf = 1'b1;
    end
    reg_rd(3'd4, d);
    n_tests++; if (d !== {2'b0, ovf, 1'b0, 1'b1, 1'b1, 2'b0}) begin n_fail++; $display("FAIL ovf_status: got %h, required %h", d, {2'b0, ovf, 1'b0, 1'b1, 1'b1, 2'b0}); end
    for (int i = 0; i < 4; i++) begin
      reg_rd(3'd1, d);
      n_tests++; if (d !== rxq[i]) begin n_fail++; $display("FAIL ovf_rx%0d: got %h, required %h", i, d, rxq[i]); end
    end
    reg_rd(3'd4, d);
    n_tests++; if (d !== 8'h34) begin n_fail++; $display("FAIL ovf_sticky: got %h, required 34", d); end
    reg_wr(3'd4, 8'h20);
    reg_rd(3'd4, d);
    n_tests++; if (d !== 8'h14) begin n_fail++; $display("FAIL ovf_clear: got %h, required 14", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int c = 0, ne;
    loopb = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0, 8'd1);
    reg_wr(3'd3, 8'h01);
    reg_wr(3'd1, 8'h5A);
    while (edges < 7 && c < 1000) begin @(negedge clk); #1; c++; end
    n_tests++; if (edges != 7) begin n_fail++; $display("FAIL rmid_reach: got %0d edges, required 7", edges); end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    n_tests++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rmid_sclk: got %b, required 0", sclk); end
    n_tests++; if (cs_n !== 4'hF) begin n_fail++; $display("FAIL rmid_cs_n: got %h, required f", cs_n); end
    n_tests++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL rmid_mosi: got %b, required 0", mosi); end
    ne = nedges;
    repeat (60) @(negedge clk);
    n_tests++; if (nedges != ne || nbytes != 0) begin n_fail++; $display("FAIL rmid_quiet: got %0d edges %0d bytes, required %0d and 0", nedges, nbytes, ne); end
    reg_rd(3'd4, d);
    n_tests++; if (d !== 8'h14) begin n_fail++; $display("FAIL rmid_status: got %h, required 14", d); end
    reg_rd(3'd0, d);
    n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL rmid_div: got %h, required 01", d); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) slave_data[i] = 8'h00;
    test_reset();
    clear_mon();
    test_regs();
    test_mode0();
    test_mode3_lsb();
    test_tx_fill();
    test_random();
    test_rx_ovf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
